// File: rtl/prio_enc_pkg.sv
// Shared constants for the priority encoder / hex display slice:
// active-low 7-segment codes (gfedcba) and a constant-foldable clog2.
package prio_enc_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;

    // Ceiling log2, never below 1 so a 2-input encoder still has a 1-bit index.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/seg7_dec.sv
// Combinational 4-bit to active-low 7-segment decoder (gfedcba).
module seg7_dec
    import prio_enc_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    // Nibble to segment lookup.
    always_comb begin
        seg = SEG_BLANK;
        case (nib)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/prio_enc_hex.sv
// Two-stage priority encoder with registered hex display, change pulse
// and request-event counter. Define PRIO_ENC_HEX_LZB_EN to blank leading
// zero digits above the most significant nonzero nibble of y.
module prio_enc_hex
    import prio_enc_pkg::*;
#(
    parameter int unsigned N         = 16,
    parameter bit          MSB_FIRST = 1'b1,
    localparam int unsigned W        = clog2(N),
    localparam int unsigned D        = (W + 3) / 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   x,
    input  logic           en,
    input  logic           hold,
    output logic [W-1:0]   y,
    output logic           stat,
    output logic           chg,
    output logic [7:0]     evcnt,
    output logic [7*D-1:0] hex
);

    logic [N-1:0]   xs;
    logic [W-1:0]   y_nxt;
    logic           stat_nxt;
    logic [4*D-1:0] y_pad;
    logic [7*D-1:0] seg_raw;
    logic [7*D-1:0] hex_nxt;
    logic [D-1:0]   show;
`ifdef PRIO_ENC_HEX_LZB_EN
    logic [D-1:0]   nz_above;
`endif

    // Stage 1: sample requests; hold freezes, otherwise en gates to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    xs <= '0;
        else if (hold) xs <= xs;
        else if (en)   xs <= x;
        else           xs <= '0;
    end

    // Priority encode of the sampled vector; later hits in the scan win.
    always_comb begin
        y_nxt    = '0;
        stat_nxt = |xs;
        for (int unsigned i = 0; i < N; i++) begin
            if (MSB_FIRST) begin
                if (xs[i]) y_nxt = W'(i);
            end else begin
                if (xs[N-1-i]) y_nxt = W'(N - 1 - i);
            end
        end
        y_pad           = '0;
        y_pad[W-1:0]    = y_nxt;
    end

    for (genvar k = 0; k < D; k++) begin : g_dig
        seg7_dec u_dec (
            .nib (y_pad[4*k +: 4]),
            .seg (seg_raw[7*k +: 7])
        );
    end

    // Per-digit visibility: everything blank when idle.
    always_comb begin
        show    = {D{stat_nxt}};
        hex_nxt = '0;
`ifdef PRIO_ENC_HEX_LZB_EN
        // nz_above[k]: some nibble at position k or higher is nonzero.
        nz_above        = '0;
        nz_above[D-1]   = |y_pad[4*D-1 -: 4];
        for (int unsigned j = 1; j < D; j++) begin
            nz_above[D-1-j] = nz_above[D-j] | (|y_pad[4*(D-1-j) +: 4]);
        end
        for (int unsigned k = 1; k < D; k++) begin
            show[k] = stat_nxt & nz_above[k];
        end
`endif
        for (int unsigned k = 0; k < D; k++) begin
            hex_nxt[7*k +: 7] = show[k] ? seg_raw[7*k +: 7] : SEG_BLANK;
        end
    end

    // Stage 2: register encode result, flag changes, count idle->active edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y     <= '0;
            stat  <= 1'b0;
            chg   <= 1'b0;
            evcnt <= '0;
            hex   <= {D{SEG_BLANK}};
        end else begin
            y     <= y_nxt;
            stat  <= stat_nxt;
            hex   <= hex_nxt;
            chg   <= ({stat_nxt, y_nxt} != {stat, y});
            evcnt <= evcnt + 8'(stat_nxt & ~stat);
        end
    end

endmodule

// File: tb/tb_prio_enc_hex.sv
// Scoreboard bench for prio_enc_hex: three instances (N=8 MSB-first,
// N=8 LSB-first, N=64 MSB-first) share the request stream.
module tb_prio_enc_hex;

    typedef struct packed {
        logic        s8;
        logic [2:0]  yh;
        logic [2:0]  yl;
        logic [6:0]  hh;
        logic [6:0]  hl;
        logic        s64;
        logic [5:0]  y64;
        logic [13:0] h64;
        logic        c8h;
        logic        c8l;
        logic        c64;
        logic [7:0]  ev8;
        logic [7:0]  ev64;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        hold;
    logic [63:0] x64;
    logic [7:0]  x8;
    assign x8 = x64[7:0];

    logic [2:0]  d_y8h, d_y8l;
    logic [5:0]  d_y64;
    logic        d_s8h, d_s8l, d_s64;
    logic        d_c8h, d_c8l, d_c64;
    logic [7:0]  d_ev8h, d_ev8l, d_ev64;
    logic [6:0]  d_h8h, d_h8l;
    logic [13:0] d_h64;

    int checks = 0;
    int errors = 0;

    logic [6:0] segt [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    exp_t        sbq [$];
    logic [63:0] xs_m;
    logic        p_s8, p_s64;
    logic [2:0]  p_yh, p_yl;
    logic [5:0]  p_y64;
    logic [7:0]  ev8_m, ev64_m;

    prio_enc_hex #(.N(8), .MSB_FIRST(1'b1)) u_8h (
        .clk(clk), .rst_n(rst_n), .x(x8), .en(en), .hold(hold),
        .y(d_y8h), .stat(d_s8h), .chg(d_c8h), .evcnt(d_ev8h), .hex(d_h8h));
    prio_enc_hex #(.N(8), .MSB_FIRST(1'b0)) u_8l (
        .clk(clk), .rst_n(rst_n), .x(x8), .en(en), .hold(hold),
        .y(d_y8l), .stat(d_s8l), .chg(d_c8l), .evcnt(d_ev8l), .hex(d_h8l));
    prio_enc_hex #(.N(64), .MSB_FIRST(1'b1)) u_64 (
        .clk(clk), .rst_n(rst_n), .x(x64), .en(en), .hold(hold),
        .y(d_y64), .stat(d_s64), .chg(d_c64), .evcnt(d_ev64), .hex(d_h64));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [63:0] v);
        exp_t r;
        logic [6:0] d1;
        r = '0;
        for (int i = 0; i < 8; i++) if (v[i]) r.yh = 3'(i);
        for (int i = 7; i >= 0; i--) if (v[i]) r.yl = 3'(i);
        for (int i = 0; i < 64; i++) if (v[i]) r.y64 = 6'(i);
        r.s8  = |v[7:0];
        r.s64 = |v;
        r.hh  = r.s8 ? segt[{1'b0, r.yh}] : 7'h7F;
        r.hl  = r.s8 ? segt[{1'b0, r.yl}] : 7'h7F;
        d1    = r.s64 ? segt[{2'b00, r.y64[5:4]}] : 7'h7F;
`ifdef PRIO_ENC_HEX_LZB_EN
        if (r.y64[5:4] == 2'b00) d1 = 7'h7F;
`endif
        r.h64 = {d1, r.s64 ? segt[r.y64[3:0]] : 7'h7F};
        return r;
    endfunction

    // One clock: drive inputs, push expectation, pop the entry due now.
    task automatic tick(input logic [63:0] xv, input logic e, input logic h,
                        output exp_t o);
        x64  = xv;
        en   = e;
        hold = h;
        if (!h) xs_m = e ? xv : 64'd0;
        sbq.push_back(model(xs_m));
        @(posedge clk);
        #1;
        o     = sbq.pop_front();
        o.c8h = {o.s8, o.yh} != {p_s8, p_yh};
        o.c8l = {o.s8, o.yl} != {p_s8, p_yl};
        o.c64 = {o.s64, o.y64} != {p_s64, p_y64};
        if (o.s8 && !p_s8)   ev8_m++;
        if (o.s64 && !p_s64) ev64_m++;
        o.ev8  = ev8_m;
        o.ev64 = ev64_m;
        p_s8 = o.s8; p_yh = o.yh; p_yl = o.yl; p_s64 = o.s64; p_y64 = o.y64;
    endtask

    // Asserts reset mid-cycle and checks outputs clear without a clock edge.
    task automatic do_reset;
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({d_y8h, d_s8h, d_c8h, d_ev8h, d_h8h} !== {3'd0, 1'b0, 1'b0, 8'd0, 7'h7F}) begin
            errors++;
            $display("FAIL rst_8h got %h exp %h", {d_y8h, d_s8h, d_c8h, d_ev8h, d_h8h},
                     {3'd0, 1'b0, 1'b0, 8'd0, 7'h7F});
        end
        checks++;
        if ({d_y8l, d_s8l, d_c8l, d_ev8l, d_h8l} !== {3'd0, 1'b0, 1'b0, 8'd0, 7'h7F}) begin
            errors++;
            $display("FAIL rst_8l got %h exp %h", {d_y8l, d_s8l, d_c8l, d_ev8l, d_h8l},
                     {3'd0, 1'b0, 1'b0, 8'd0, 7'h7F});
        end
        checks++;
        if ({d_y64, d_s64, d_c64, d_ev64, d_h64} !== {6'd0, 1'b0, 1'b0, 8'd0, 14'h3FFF}) begin
            errors++;
            $display("FAIL rst_64 got %h exp %h", {d_y64, d_s64, d_c64, d_ev64, d_h64},
                     {6'd0, 1'b0, 1'b0, 8'd0, 14'h3FFF});
        end
        xs_m = '0;
        sbq.delete();
        sbq.push_back(model(64'd0));
        p_s8 = 0; p_yh = 0; p_yl = 0; p_s64 = 0; p_y64 = 0;
        ev8_m = 0; ev64_m = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        exp_t e;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick(64'd0, 1'b1, 1'b0, e);
            checks++;
            if ({d_c8h, d_c8l, d_c64, d_s8h, d_s64} !== 5'b0) begin
                errors++;
                $display("FAIL reset_exit_chg got %b exp 00000",
                         {d_c8h, d_c8l, d_c64, d_s8h, d_s64});
            end
        end
    endtask

    task automatic test_encode;
        exp_t e;
        tick(64'h29, 1'b1, 1'b0, e);
        tick(64'h29, 1'b1, 1'b0, e);
        checks++;
        if ({d_y8h, d_s8h, d_h8h, d_c8h, d_ev8h} !== {3'd5, 1'b1, 7'h12, 1'b1, 8'd1}) begin
            errors++;
            $display("FAIL enc_msb got %h exp %h", {d_y8h, d_s8h, d_h8h, d_c8h, d_ev8h},
                     {3'd5, 1'b1, 7'h12, 1'b1, 8'd1});
        end
        checks++;
        if ({d_y8l, d_s8l, d_h8l, d_c8l} !== {3'd0, 1'b1, 7'h40, 1'b1}) begin
            errors++;
            $display("FAIL enc_lsb got %h exp %h", {d_y8l, d_s8l, d_h8l, d_c8l},
                     {3'd0, 1'b1, 7'h40, 1'b1});
        end
        tick(64'h29, 1'b1, 1'b0, e);
        checks++;
        if ({d_c8h, d_c8l, d_ev8h} !== {1'b0, 1'b0, 8'd1}) begin
            errors++;
            $display("FAIL enc_single_pulse got %h exp %h", {d_c8h, d_c8l, d_ev8h},
                     {1'b0, 1'b0, 8'd1});
        end
        tick(64'h0, 1'b1, 1'b0, e);
        tick(64'h0, 1'b1, 1'b0, e);
        checks++;
        if ({d_s8l, d_y8l, d_h8l, d_c8l} !== {1'b0, 3'd0, 7'h7F, 1'b1}) begin
            errors++;
            $display("FAIL enc_clear got %h exp %h", {d_s8l, d_y8l, d_h8l, d_c8l},
                     {1'b0, 3'd0, 7'h7F, 1'b1});
        end
    endtask

    task automatic test_wide;
        exp_t e;
        logic [6:0] d1_exp;
        tick(64'd1 << 45, 1'b1, 1'b0, e);
        tick(64'd1 << 45, 1'b1, 1'b0, e);
        checks++;
        if ({d_y64, d_h64} !== {6'd45, 7'h24, 7'h21}) begin
            errors++;
            $display("FAIL wide_45 got %h exp %h", {d_y64, d_h64}, {6'd45, 7'h24, 7'h21});
        end
        tick(64'd1 << 3, 1'b1, 1'b0, e);
        tick(64'd1 << 3, 1'b1, 1'b0, e);
        d1_exp = 7'h40;
`ifdef PRIO_ENC_HEX_LZB_EN
        d1_exp = 7'h7F;
`endif
        checks++;
        if ({d_y64, d_h64} !== {6'd3, d1_exp, 7'h30}) begin
            errors++;
            $display("FAIL wide_3 got %h exp %h", {d_y64, d_h64}, {6'd3, d1_exp, 7'h30});
        end
    endtask

    task automatic test_enable;
        exp_t e;
        tick(64'h29, 1'b1, 1'b0, e);
        tick(64'h29, 1'b1, 1'b0, e);
        tick(64'h29, 1'b0, 1'b0, e);
        tick(64'h29, 1'b0, 1'b0, e);
        checks++;
        if ({d_s8h, d_y8h, d_h8h, d_c8h, d_s64, d_c64} !== {1'b0, 3'd0, 7'h7F, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL en_low got %h exp %h", {d_s8h, d_y8h, d_h8h, d_c8h, d_s64, d_c64},
                     {1'b0, 3'd0, 7'h7F, 1'b1, 1'b0, 1'b1});
        end
    endtask

    task automatic test_hold;
        exp_t e;
        logic [7:0] ev_before;
        tick(64'h29, 1'b1, 1'b0, e);
        tick(64'h29, 1'b1, 1'b0, e);
        tick(64'h29, 1'b1, 1'b0, e);
        ev_before = ev8_m;
        for (int i = 0; i < 10; i++) begin
            tick((i % 2 == 0) ? 64'h80 : 64'h0, 1'b1, 1'b1, e);
            checks++;
            if ({d_y8h, d_s8h, d_h8h, d_c8h, d_c64, d_ev8h} !==
                {3'd5, 1'b1, 7'h12, 1'b0, 1'b0, ev_before}) begin
                errors++;
                $display("FAIL hold_%0d got %h exp %h", i,
                         {d_y8h, d_s8h, d_h8h, d_c8h, d_c64, d_ev8h},
                         {3'd5, 1'b1, 7'h12, 1'b0, 1'b0, ev_before});
            end
        end
    endtask

    task automatic test_evcnt_wrap;
        exp_t e;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            tick(64'h1, 1'b1, 1'b0, e);
            tick(64'h0, 1'b1, 1'b0, e);
        end
        tick(64'h0, 1'b1, 1'b0, e);
        tick(64'h0, 1'b1, 1'b0, e);
        checks++;
        if ({d_ev8h, d_ev8l, d_ev64} !== {8'd44, 8'd44, 8'd44}) begin
            errors++;
            $display("FAIL evcnt_wrap got %0d/%0d/%0d exp 44", d_ev8h, d_ev8l, d_ev64);
        end
    endtask

    task automatic test_reset_mid;
        exp_t e;
        tick(64'h80, 1'b1, 1'b0, e);
        tick(64'h80, 1'b1, 1'b0, e);
        tick(64'h01, 1'b1, 1'b0, e);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick(64'h0, 1'b1, 1'b0, e);
            checks++;
            if ({d_s8h, d_s64, d_c8h, d_ev8h, d_ev64} !== {1'b0, 1'b0, 1'b0, 8'd0, 8'd0}) begin
                errors++;
                $display("FAIL reset_mid_%0d got %h exp 0", i,
                         {d_s8h, d_s64, d_c8h, d_ev8h, d_ev64});
            end
        end
    endtask

    task automatic test_random;
        exp_t e;
        logic [63:0] v;
        for (int i = 0; i < 400; i++) begin
            v = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) v = 64'd0;
            if ($urandom_range(0, 2) == 0) v = v & 64'hFF;
            tick(v, $urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0, e);
            checks++;
            if ({d_y8h, d_s8h, d_h8h, d_c8h, d_ev8h} !== {e.yh, e.s8, e.hh, e.c8h, e.ev8}) begin
                errors++;
                $display("FAIL rnd_8h@%0d got %h exp %h", i, {d_y8h, d_s8h, d_h8h, d_c8h, d_ev8h},
                         {e.yh, e.s8, e.hh, e.c8h, e.ev8});
            end
            checks++;
            if ({d_y8l, d_s8l, d_h8l, d_c8l, d_ev8l} !== {e.yl, e.s8, e.hl, e.c8l, e.ev8}) begin
                errors++;
                $display("FAIL rnd_8l@%0d got %h exp %h", i, {d_y8l, d_s8l, d_h8l, d_c8l, d_ev8l},
                         {e.yl, e.s8, e.hl, e.c8l, e.ev8});
            end
            checks++;
            if ({d_y64, d_s64, d_h64, d_c64, d_ev64} !== {e.y64, e.s64, e.h64, e.c64, e.ev64}) begin
                errors++;
                $display("FAIL rnd_64@%0d got %h exp %h", i, {d_y64, d_s64, d_h64, d_c64, d_ev64},
                         {e.y64, e.s64, e.h64, e.c64, e.ev64});
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        hold  = 1'b0;
        x64   = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_encode();
        test_wide();
        test_enable();
        test_hold();
        test_reset_mid();
        test_random();
        test_evcnt_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prio_enc_hex.md
PRIO_ENC_HEX -- requirements
Module: prio_enc_hex

Interface
REQ-001 Parameter N, default 16: number of request inputs, legal range 2..64.
REQ-002 Parameter MSB_FIRST, default 1: 1 means the highest set index wins, 0 means the lowest set index wins.
REQ-003 Derived constants: W = clog2(N), floor 1; D = ceil(W/4), the number of hex digits.
REQ-004 clk  in  1  system clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 x  in  N  request vector.
REQ-007 en  in  1  encoder enable.
REQ-008 hold  in  1  freeze: while high, the sampled input is not updated.
REQ-009 y  out  W  encoded index, registered.
REQ-010 stat  out  1  at least one request bit set, registered.
REQ-011 chg  out  1  one-cycle pulse when {stat,y} changes.
REQ-012 evcnt  out  8  count of stat rising edges.
REQ-013 hex  out  7*D  active-low segments; digit k occupies bits [7k+6:7k] and shows y nibble k.

Function
REQ-014 Stage 1: xs <= (en & ~hold) ? x : (hold ? xs : 0), i.e. hold takes priority over en.
REQ-015 Stage 2: y, stat and hex are registered from the priority encode of xs.
- Latency from x to y is 2 cycles.
REQ-016 stat = |xs; when stat = 0, y = 0.
REQ-017 MSB_FIRST=1: y = index of the highest set bit of xs. MSB_FIRST=0: y = index of the lowest set bit.
REQ-018 Bits of y above the nibble boundary (W not a multiple of 4) display as zero padding.
REQ-019 Segment table, 0..F = 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex, segments gfedcba, active-low).
REQ-020 stat = 0 drives every digit to blank, 7'h7F.
REQ-021 chg = 1 for exactly one cycle, in the cycle after stage 2 registers a {stat,y} that differs from its previous value.
REQ-022 evcnt increments when stat goes 0->1, wraps 255->0, and is unaffected by hold.
REQ-023 en deasserted (and hold low): xs clears, so 2 cycles later stat=0, y=0, hex blank, and chg pulses if the prior state was nonzero.
REQ-024 hold asserted: y, stat and hex stay constant, and chg stays 0 after the in-flight value drains, i.e. within 1 cycle.

Reset
REQ-025 rst_n low asynchronously clears: xs=0, y=0, stat=0, chg=0, evcnt=0, hex=all 7'h7F.
REQ-026 First valid output is 2 cycles after rst_n deasserts; no chg pulse is generated by leaving reset.
REQ-027 Reset asserted mid-operation discards in-flight data and does not count an event.

Configuration
REQ-028 Macro PRIO_ENC_HEX_LZB_EN defined: leading-zero blanking.
- Digits above the most significant nonzero nibble of y are blanked.
- Digit 0 always shows its value while stat=1.
REQ-029 Macro PRIO_ENC_HEX_LZB_EN undefined: all D digits are shown whenever stat=1.

Structure
REQ-030 Package prio_enc_pkg holds the segment constants SEG_BLANK and SEG_0..SEG_F, plus the clog2 helper function.
REQ-031 Sub-module seg7_dec: combinational 4-bit to 7-segment decoder, instantiated D times.

Verification
REQ-032 N=8, MSB_FIRST=1, x=8'b0010_1001, en=1 -> after 2 cycles: y=5, stat=1, hex=7'h12, chg pulses once, evcnt=1.
REQ-033 N=8, MSB_FIRST=0, same x -> y=0, stat=1, hex=7'h40; then x=0 -> stat=0, hex=7'h7F, chg pulses.
REQ-034 N=64, x=1<<45, LZB macro defined -> y=45 (0x2D): digit1=7'h24, digit0=7'h21; with x=1<<3 -> digit1=7'h7F, digit0=7'h30.
REQ-035 hold=1 with x toggling every cycle for 10 cycles -> y, stat and hex unchanged, chg=0 throughout, evcnt unchanged.
REQ-036 Toggle x between 0 and 1 300 times -> evcnt=300 mod 256=44.
- Pulsing rst_n low mid-stream -> all outputs reach reset values immediately, without waiting for clk.
